// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed NDIG-digit 7-segment driver with frame-coherent input snapshot
module seg7_scan_driver #(
    parameter int NDIG         = 8,
    parameter int PRESC        = 100000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [4*NDIG-1:0] digits,
    input  logic [NDIG-1:0]   dp,
    input  logic [NDIG-1:0]   dig_en,
    input  logic [NDIG-1:0]   blink,
    input  logic              lz_blank,
    output logic [7:0]        an,
    output logic [7:0]        sgm,
    output logic              frame_start
);
    localparam int PW = $clog2(PRESC);
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] dig_q, dig_d;
    logic [NDIG-1:0]   dp_q, dp_d, den_q, den_d, blink_q, blink_d;
    logic              load_pend_q, load_pend_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic              phase_q, phase_d;
    logic [7:0]        an_q, an_d, sgm_q, sgm_d;
    logic              frame_start_q, frame_start_d;
    logic              tick, last, load, zrun, lz_dark, dark;
    logic [NDIG-1:0]   lead_zero;
    logic [3:0]        cur;

    // Flag digits that are zero along with every more-significant digit
    always_comb begin
        zrun      = 1'b1;
        lead_zero = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            zrun         = zrun && dig_q[4*k +: 4] == 4'h0;
            lead_zero[k] = zrun;
        end
    end

    // Scan sequencing, snapshot loading, blink phase and next display outputs
    always_comb begin
        tick          = en && presc_q == PW'(PRESC - 1);
        last          = idx_q == IW'(NDIG - 1);
        load          = (tick && last) || (en && load_pend_q);
        presc_d       = tick ? '0 : presc_q + PW'(en);
        idx_d         = tick ? (last ? '0 : idx_q + 1'b1) : idx_q;
        dig_d         = load ? digits : dig_q;
        dp_d          = load ? dp : dp_q;
        den_d         = load ? dig_en : den_q;
        blink_d       = load ? blink : blink_q;
        load_pend_d   = load_pend_q && !load;
        frame_d       = load ? (frame_q == FW'(BLINK_FRAMES - 1) ? '0 : frame_q + 1'b1) : frame_q;
        phase_d       = phase_q ^ (load && frame_q == FW'(BLINK_FRAMES - 1));
        frame_start_d = load;
        cur           = dig_q[{idx_q, 2'b00} +: 4];
        dark          = !den_q[idx_q] || (blink_q[idx_q] && phase_q);
        lz_dark       = lz_blank && idx_q != '0 && lead_zero[idx_q];
        an_d          = en && presc_q >= PW'(GUARD) ? ~(8'd1 << idx_q) : 8'hFF;
        sgm_d         = !en || dark ? 8'hFF : {~dp_q[idx_q], lz_dark ? 7'h7F : GLYPH[cur]};
    end

    // State and registered outputs; reset darkens the display immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q       <= '0;
            idx_q         <= '0;
            dig_q         <= '0;
            dp_q          <= '0;
            den_q         <= '0;
            blink_q       <= '0;
            load_pend_q   <= 1'b1;
            frame_q       <= '0;
            phase_q       <= 1'b0;
            an_q          <= 8'hFF;
            sgm_q         <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            dig_q         <= dig_d;
            dp_q          <= dp_d;
            den_q         <= den_d;
            blink_q       <= blink_d;
            load_pend_q   <= load_pend_d;
            frame_q       <= frame_d;
            phase_q       <= phase_d;
            an_q          <= an_d;
            sgm_q         <= sgm_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign sgm         = sgm_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed and randomized checks against a frame-position reference model
module tb_seg7_scan_driver;
    localparam int NDIG  = 4;
    localparam int PRESC = 8;
    localparam int GUARD = 2;
    localparam int BF    = 2;
    localparam int FRAME = NDIG * PRESC;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, lz_blank = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp = '0, dig_en = '0, blink = '0;
    logic [7:0]  an, sgm;
    logic        frame_start;
    int          total = 0, bad = 0;
    bit          chk_on = 1'b0;
    logic [6:0]  glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [7:0]  exp1234 [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0]  exp00a0 [4] = '{8'hC0, 8'h88, 8'hFF, 8'h7F};
    logic [15:0] masks [4] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F};

    int          pos = 0, loads = 0;
    bit          pend = 1'b1;
    logic [15:0] s_dig = '0;
    logic [3:0]  s_dp = '0, s_en = '0, s_bl = '0;
    logic [7:0]  e_an = 8'hFF, e_sgm = 8'hFF;
    logic        e_fs = 1'b0;

    seg7_scan_driver #(.NDIG(NDIG), .PRESC(PRESC), .GUARD(GUARD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .dp(dp), .dig_en(dig_en),
        .blink(blink), .lz_blank(lz_blank), .an(an), .sgm(sgm), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] disp(input int k, input bit lz);
        logic [3:0] v;
        bit         ph;
        v  = 4'(s_dig >> (4 * k));
        ph = ((loads / BF) % 2) == 1;
        if (!s_en[k] || (s_bl[k] && ph)) return 8'hFF;
        return {~s_dp[k], (lz && k != 0 && (s_dig >> (4 * k)) == 16'h0) ? 7'h7F : glyph[v]};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos   <= 0;
            loads <= 0;
            pend  <= 1'b1;
            s_dig <= '0;
            s_dp  <= '0;
            s_en  <= '0;
            s_bl  <= '0;
            e_an  <= 8'hFF;
            e_sgm <= 8'hFF;
            e_fs  <= 1'b0;
        end else begin : step
            int k;
            bit ld;
            k  = pos / PRESC;
            ld = en && (pend || pos == FRAME - 1);
            e_an  <= (en && pos % PRESC >= GUARD) ? ~(8'd1 << k) : 8'hFF;
            e_sgm <= en ? disp(k, lz_blank) : 8'hFF;
            e_fs  <= ld;
            if (en) pos <= (pos + 1) % FRAME;
            if (ld) begin
                s_dig <= digits;
                s_dp  <= dp;
                s_en  <= dig_en;
                s_bl  <= blink;
                pend  <= 1'b0;
                loads <= loads + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("an", an, e_an);
            chk("sgm", sgm, e_sgm);
            chk("fs", 8'(frame_start), 8'(e_fs));
        end
    end

    task automatic wait_lit(input int k);
        logic [7:0] t;
        int         n;
        t = ~(8'd1 << k);
        n = 0;
        while (an == t && n < 100) begin @(negedge clk); n++; end
        while (an != t && n < 200) begin @(negedge clk); n++; end
        chk("wait_lit", 8'(an == t), 8'd1);
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        while (!frame_start && n < 200) begin @(negedge clk); n++; end
        chk("wait_fs", 8'(frame_start), 8'd1);
    endtask

    task automatic count_lit(input int k, input int want);
        int n;
        n = 0;
        while (an == ~(8'd1 << k) && n < 20) begin @(negedge clk); n++; end
        chk("lit_len", 8'(n), 8'(want));
    endtask

    task automatic first_anode(input logic [7:0] want);
        int n;
        n = 0;
        while (an == 8'hFF && n < 50) begin @(negedge clk); n++; end
        chk("first_an", an, want);
    endtask

    initial begin
        #1 rst = 1'b0;
        chk_on = 1'b1;
        en = 1'b1;
        digits = 16'h1234;
        dig_en = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_an", an, 8'hFF);
        chk("rst_sgm", sgm, 8'hFF);
        chk("rst_fs", 8'(frame_start), 8'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("fs_first", 8'(frame_start), 8'd1);
        first_anode(8'hFE);
        for (int k = 0; k < NDIG; k++) begin
            wait_lit(k);
            chk("sgm_1234", sgm, exp1234[k]);
            count_lit(k, PRESC - GUARD);
        end

        digits = 16'h00A0;
        dp = 4'b1000;
        lz_blank = 1'b1;
        wait_fs();
        for (int k = 0; k < NDIG; k++) begin
            wait_lit(k);
            chk("sgm_lz", sgm, exp00a0[k]);
        end
        lz_blank = 1'b0;
        wait_lit(3);
        chk("sgm_nolz3", sgm, 8'h40);
        wait_lit(2);
        chk("sgm_nolz2", sgm, 8'hC0);

        digits = 16'h1234;
        dp = 4'b0000;
        wait_fs();
        wait_lit(1);
        digits = 16'h5678;
        wait_lit(2);
        chk("old_frame2", sgm, 8'hA4);
        wait_lit(3);
        chk("old_frame3", sgm, 8'hF9);
        wait_fs();
        wait_lit(0);
        chk("new_frame0", sgm, 8'h80);
        wait_lit(3);
        chk("new_frame3", sgm, 8'h92);

        blink = 4'b0001;
        repeat (8 * FRAME) @(negedge clk);
        dig_en = 4'b1110;
        wait_fs();
        wait_lit(0);
        chk("den_off", sgm, 8'hFF);
        blink = 4'b0000;
        dig_en = 4'hF;

        wait_lit(2);
        repeat (2) @(negedge clk);
        en = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("pause_an", an, 8'hFF);
            chk("pause_sgm", sgm, 8'hFF);
        end
        en = 1'b1;
        wait_lit(2);
        count_lit(2, 3);
        first_anode(8'hF7);

        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                digits   = 16'($urandom) & masks[$urandom_range(0, 3)];
                dp       = 4'($urandom);
                dig_en   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                blink    = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
                lz_blank = 1'($urandom);
            end
            en = $urandom_range(0, 15) != 0;
        end

        @(negedge clk);
        en = 1'b1;
        wait_lit(1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_an", an, 8'hFF);
        chk("async_sgm", sgm, 8'hFF);
        chk("async_fs", 8'(frame_start), 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("fs_rerelease", 8'(frame_start), 8'd1);
        first_anode(8'hFE);

        repeat (300) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                digits   = 16'($urandom) & masks[$urandom_range(0, 3)];
                dp       = 4'($urandom);
                blink    = 4'($urandom);
                lz_blank = 1'($urandom);
            end
            en = $urandom_range(0, 7) != 0;
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised time-multiplexed 7-segment display driver for the stopwatch/counter designs. It scans NDIG digits instead of two, with a programmable refresh prescaler and anode guard time against ghosting. It adds hex decoding, per-digit decimal points, per-digit enable/blink, and leading-zero blanking. Inputs are snapshotted once per scan frame, so a frame never mixes old and new digit values.

## Interface
- NDIG, 8: digits scanned, 1..8.
- PRESC, 100000: clk cycles per digit slot, ≥ 4 (1 kHz slot rate at 100 MHz).
- GUARD, 2: cycles at slot start with all anodes off, 1..PRESC-2.
- BLINK_FRAMES, 64: frames per blink half-period, ≥ 1.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  scan enable; 0 pauses the scan and blanks the display.
- digits  in  4*NDIG  hex digit values; digit i = digits[4i+3:4i], i=0 rightmost.
- dp  in  NDIG  decimal point request per digit, 1 = lit.
- dig_en  in  NDIG  per-digit enable, 0 = digit fully dark.
- blink  in  NDIG  per-digit blink request.
- lz_blank  in  1  leading-zero blanking enable.
- an  out  8  anodes, active-low; an[i] drives digit i; bits ≥ NDIG are held 1.
- sgm  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
- frame_start  out  1  one-cycle pulse when the snapshot loads.

## Operation
- State:
  - presc counter, 0..PRESC-1.
  - idx, 0..NDIG-1.
  - snapshot registers for digits, dp, dig_en and blink.
  - load_pend flag.
  - frame counter, 0..BLINK_FRAMES-1.
  - blink phase bit.
- Reset (rst=0) values:
  - presc=0, idx=0, snapshot=0, frame counter=0, phase=0, load_pend=1.
  - an=8'hFF, sgm=8'hFF, frame_start=0.
- With en=1, presc increments each cycle. tick = (presc==PRESC-1). On tick: presc←0 and idx←idx+1, wrapping NDIG-1→0.
- Snapshot load condition: (tick & idx==NDIG-1) | (en & load_pend).
  - Loads digits, dp, dig_en and blink.
  - Clears load_pend.
  - Pulses frame_start.
  - Advances the frame counter. On wrap BLINK_FRAMES-1→0, phase toggles.
- Glyphs {g..a}, 0-F:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - Blank = 7F.
  - sgm[7] = ~dp_bit.
- Digit k (snapshot values) is dark (sgm=FF) if any of the following holds:
  - dig_en[k]=0;
  - blink[k]=1 and phase=1;
  - leading zero: lz_blank=1, k≠0, and every digit from NDIG-1 down to k equals 0. The decimal point is still shown for a leading-zero-blanked digit.
- Anode: an[idx]=0 only while presc ≥ GUARD. All other anode bits are 1.
- en=0:
  - presc, idx, snapshot and the frame counter hold.
  - an=FF, sgm=FF.
  - load_pend is unchanged.
  - On return to en=1, the scan resumes from the held presc/idx.

## Timing
- an and sgm are registered: one cycle of latency from presc/idx.
  - The cycle after a tick: all anodes are off.
  - Digit idx is driven for PRESC-GUARD cycles per slot.
- Frame period is NDIG*PRESC cycles.
- Snapshot timing:
  - Input changes are visible from the first slot of the next frame: digit 0, GUARD+1 cycles after frame_start.
  - First snapshot loads on the first en=1 cycle after reset release.
- frame_start is asserted in the cycle after the load condition, coincident with the updated snapshot registers.
- Blink half-period is BLINK_FRAMES frames.
- Reset assertion mid-slot forces an=FF and sgm=FF asynchronously. No partial-digit glitch follows release.
- NDIG=1: idx is constant 0, and every tick loads the snapshot.

## Test plan
- Bench parameters: NDIG=4, PRESC=8, GUARD=2, BLINK_FRAMES=2. Stimulus: digits=16'h1234, all dig_en=1, en=1, release reset.
  - frame_start 1 cycle after release.
  - an cycles E,D,B,7, each low 6 of 8 cycles.
  - sgm sequence 99,B0,A4,F9 (digit 0 shows 4, digit 1 shows 3, etc.).
- digits=16'h00A0, lz_blank=1, dp=4'b1000: digit 3 shows 7F (dp only), digit 2 shows FF, digit 1 shows 88, digit 0 shows C0. lz_blank=0 → digit 3 shows 40, digit 2 shows C0.
- Change digits mid-frame from 1234 to 5678: the current frame still shows 1234; 5678 appears after the next frame_start.
- blink=4'b0001: digit 0 is dark for 2 frames, lit for 2 frames, repeating. dig_en=4'b1110 → digit 0 is always FF.
- en=0 for 20 cycles mid-slot 2: an=FF and sgm=FF throughout; after re-enable, slot 2 completes its remaining cycles, then slot 3 follows.
- Assert rst low mid-frame: an/sgm go FF immediately, without a clock edge. After release, idx=0 and the snapshot reloads on the first enabled cycle.
